// File: rtl/p12_cfg_loader_if.sv
// Byte-stream host port, grid scan pins and readback port of the p12 configuration loader.
interface p12_cfg_loader_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       out_se;
   logic       out_sc;
   logic [1:0] out_cfg;
   logic       in_sc_ret;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;

   modport master (
      output s_valid, s_data, in_sc_ret,
      input  s_ready, out_se, out_sc, out_cfg, rd_valid, rd_data, busy, done
   );

   modport slave (
      input  s_valid, s_data, in_sc_ret,
      output s_ready, out_se, out_sc, out_cfg, rd_valid, rd_data, busy, done
   );
endinterface

// File: rtl/p12_cfg_loader.sv
// Loads four buffered planes (V, H, D, state) into the p12 grid scan chain and
// returns the old flop state as readback bytes while the state plane is shifted.
module p12_cfg_loader #(
   parameter int unsigned CHAIN_LEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   p12_cfg_loader_if.slave bus
);
   localparam int unsigned NBYTES = CHAIN_LEN / 8;
   localparam int unsigned KW     = $clog2(NBYTES + 1);
   localparam int unsigned IW     = $clog2(CHAIN_LEN);

   typedef enum logic [1:0] {StFill, StShift, StLatch, StDone} state_e;

   state_e                 state_q, state_d;
   logic [1:0]             p_q, p_d;
   logic [KW-1:0]          k_q, k_d;
   logic [IW-1:0]          i_q, i_d;
   logic [CHAIN_LEN-1:0]   buf_q, buf_d;
   logic [6:0]             rb_q, rb_d;
   logic                   s_ready_q, s_ready_d;
   logic                   out_se_q, out_se_d;
   logic                   out_sc_q, out_sc_d;
   logic [1:0]             out_cfg_q, out_cfg_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [7:0]             rd_data_q, rd_data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      k_d        = k_q;
      i_d        = i_q;
      buf_d      = buf_q;
      rb_d       = rb_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;

      unique case (state_q)
         StFill: begin
            if (bus.s_valid && s_ready_q) begin
               buf_d[{k_q, 3'b000} +: 8] = bus.s_data;
               k_d = k_q + 1'b1;
               if (k_q == KW'(NBYTES - 1)) begin
                  state_d = StShift;
                  i_d     = '0;
               end
            end
         end
         StShift: begin
            i_d = i_q + 1'b1;
            if (p_q == 2'd3) begin
               // Byte is complete once bit 7 is sampled; it is presented the following cycle.
               if (i_q[2:0] == 3'd7) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = {bus.in_sc_ret, rb_q};
               end else begin
                  rb_d[i_q[2:0]] = bus.in_sc_ret;
               end
            end
            if (i_q == IW'(CHAIN_LEN - 1)) begin
               state_d = (p_q == 2'd3) ? StDone : StLatch;
            end
         end
         StLatch: begin
            p_d     = p_q + 2'd1;
            k_d     = '0;
            state_d = StFill;
         end
         StDone: begin
            p_d     = 2'd0;
            k_d     = '0;
            state_d = StFill;
         end
         default: state_d = StFill;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      s_ready_d = (state_d == StFill);
      out_se_d  = (state_d == StShift);
      out_sc_d  = (state_d == StShift) ? buf_d[i_d] : 1'b0;
      out_cfg_d = (state_d == StLatch) ? (p_d + 2'd1) : 2'd0;
      done_d    = (state_d == StDone);
      busy_d    = !((state_d == StFill) && (p_d == 2'd0) && (k_d == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StFill;
         p_q        <= 2'd0;
         k_q        <= '0;
         i_q        <= '0;
         buf_q      <= '0;
         rb_q       <= '0;
         s_ready_q  <= 1'b1;
         out_se_q   <= 1'b0;
         out_sc_q   <= 1'b0;
         out_cfg_q  <= 2'd0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         p_q        <= p_d;
         k_q        <= k_d;
         i_q        <= i_d;
         buf_q      <= buf_d;
         rb_q       <= rb_d;
         s_ready_q  <= s_ready_d;
         out_se_q   <= out_se_d;
         out_sc_q   <= out_sc_d;
         out_cfg_q  <= out_cfg_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.s_ready  = s_ready_q;
   assign bus.out_se   = out_se_q;
   assign bus.out_sc   = out_sc_q;
   assign bus.out_cfg  = out_cfg_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_p12_cfg_loader.sv
// Bench for p12_cfg_loader: grid chain model, queue-based reference schedule checked every cycle,
// plus literal expectations for the fixed frame.
module tb_p12_cfg_loader;
   localparam int L  = 16;
   localparam int NB = L / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   p12_cfg_loader_if bus ();

   p12_cfg_loader #(.CHAIN_LEN(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Grid chain: out_sc enters at the top, bit 0 returns; optional flop-state restore after D latch.
   logic [L-1:0] chain;
   logic         preload_req = 1'b1;
   logic         pre_after_d = 1'b0;
   logic [L-1:0] preload_val = '0;
   always @(posedge clk) begin
      if (preload_req || (pre_after_d && bus.out_cfg == 2'd3)) chain <= preload_val;
      else if (bus.out_se) chain <= {bus.out_sc, chain[L-1:1]};
   end
   assign bus.in_sc_ret = chain[0];

   // Reference: once a plane is buffered, its whole output schedule is queued up front.
   typedef struct packed {
      logic         se;
      logic         sc;
      logic [1:0]   cfg;
      logic         rdv;
      logic [7:0]   rdd;
      logic         dn;
      logic [L-1:0] lat;
   } tup_t;

   tup_t         sched[$];
   logic [7:0]   m_bytes[$];
   int           m_plane   = 0;
   logic [7:0]   m_rd_last = 8'd0;
   logic         started   = 1'b0;
   logic         e_rdy, e_se, e_sc, e_rdv, e_busy, e_done;
   logic [1:0]   e_cfg;
   logic [7:0]   e_rdd;
   logic [L-1:0] e_lat;

   function automatic void set_fill();
      e_rdy  = 1'b1;
      e_se   = 1'b0;
      e_sc   = 1'b0;
      e_cfg  = 2'd0;
      e_rdv  = 1'b0;
      e_rdd  = m_rd_last;
      e_done = 1'b0;
      e_lat  = '0;
      e_busy = !(m_plane == 0 && m_bytes.size() == 0);
   endfunction

   function automatic void schedule();
      logic [L-1:0] data;
      logic [L-1:0] old;
      logic [7:0]   cur;
      for (int b = 0; b < NB; b++) data[8*b +: 8] = m_bytes[b];
      old = chain;
      cur = m_rd_last;
      for (int t = 0; t <= L; t++) begin
         tup_t x;
         x = '0;
         if (t < L) begin
            x.se = 1'b1;
            x.sc = data[t];
         end else if (m_plane < 3) begin
            x.cfg = 2'(m_plane + 1);
            x.lat = data;
         end else begin
            x.dn = 1'b1;
         end
         if (m_plane == 3 && t >= 8 && t % 8 == 0) begin
            cur   = old[t-8 +: 8];
            x.rdv = 1'b1;
         end
         x.rdd = cur;
         sched.push_back(x);
      end
      if (m_plane == 3) m_rd_last = cur;
      m_bytes.delete();
      m_plane = (m_plane + 1) % 4;
   endfunction

   always @(posedge clk) begin
      tup_t x;
      started = 1'b1;
      if (rst) begin
         sched.delete();
         m_bytes.delete();
         m_plane   = 0;
         m_rd_last = 8'd0;
         set_fill();
      end else begin
         if (e_rdy && bus.s_valid) begin
            m_bytes.push_back(bus.s_data);
            if (m_bytes.size() == NB) schedule();
         end
         if (sched.size() > 0) begin
            x      = sched.pop_front();
            e_rdy  = 1'b0;
            e_se   = x.se;
            e_sc   = x.sc;
            e_cfg  = x.cfg;
            e_rdv  = x.rdv;
            e_rdd  = x.rdd;
            e_done = x.dn;
            e_lat  = x.lat;
            e_busy = 1'b1;
         end else begin
            set_fill();
         end
      end
   end

   // Per-cycle compare and event log.
   int           done_cnt  = 0;
   int           done_cyc  = -100;
   int           start_cyc = 0;
   int           start_gap = 0;
   int           frame_len = 0;
   logic [7:0]   rd_log[$];
   logic         rd_dn_log[$];
   logic [L-1:0] lat_log[3];

   always @(negedge clk) begin
      cyc++;
      if (started) begin
         chk("s_ready", 32'(bus.s_ready), 32'(e_rdy));
         chk("out_se", 32'(bus.out_se), 32'(e_se));
         chk("out_sc", 32'(bus.out_sc), 32'(e_sc));
         chk("out_cfg", 32'(bus.out_cfg), 32'(e_cfg));
         chk("rd_valid", 32'(bus.rd_valid), 32'(e_rdv));
         chk("rd_data", 32'(bus.rd_data), 32'(e_rdd));
         chk("busy", 32'(bus.busy), 32'(e_busy));
         chk("done", 32'(bus.done), 32'(e_done));
         if (e_cfg != 2'd0) chk("latch_chain", 32'(chain), 32'(e_lat));
         if (bus.s_valid && bus.s_ready && !bus.busy) begin
            start_cyc = cyc;
            start_gap = cyc - done_cyc;
         end
         if (bus.out_cfg != 2'd0) lat_log[int'(bus.out_cfg) - 1] = chain;
         if (bus.rd_valid) begin
            rd_log.push_back(bus.rd_data);
            rd_dn_log.push_back(bus.done);
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc  = cyc;
            frame_len = cyc - start_cyc + 1;
         end
      end
   end

   // Stimulus: inputs change 1 time unit after the rising edge.
   logic [7:0] frame[4*NB];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ee);
      int n;
      n = 0;
      bus.s_valid = 1'b1;
      while (!bus.s_ready && n < 1000) begin
         bus.s_data = ee ? 8'hEE : b;
         tick();
         n++;
      end
      if (!bus.s_ready) begin
         n_chk++;
         n_err++;
         $display("FAIL send_timeout: s_ready stuck at 0, required 1");
      end
      bus.s_data = b;
      tick();
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
   endtask

   task automatic send_frame(input int gap, input bit ee, input bit b2b);
      int g;
      for (int j = 0; j < 4*NB; j++) begin
         send_byte(frame[j], ee);
         if (b2b && j == 0) begin
            chk("b2b_start_gap", 32'(start_gap), 32'd1);
            chk("b2b_busy_rise", 32'(bus.busy), 32'd1);
         end
         g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
         repeat (g) tick();
      end
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 3000) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done_cnt), 32'(target));
   endtask

   task automatic load_fixed();
      logic [7:0] f[8];
      f = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hAA, 8'h55, 8'h0F, 8'hF0};
      for (int j = 0; j < 8; j++) frame[j] = f[j];
   endtask

   task automatic check_latches(input string tag);
      chk({tag, "_lat_v"}, 32'(lat_log[0]), 32'h8001);
      chk({tag, "_lat_h"}, 32'(lat_log[1]), 32'h00FF);
      chk({tag, "_lat_d"}, 32'(lat_log[2]), 32'h55AA);
   endtask

   initial begin
      int dbase;
      int rbase;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      repeat (2) tick();
      rst         = 1'b0;
      preload_req = 1'b0;
      chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_out_cfg", 32'(bus.out_cfg), 32'd0);

      // Fixed frame, no stalls; readback returns the D plane left in the chain.
      load_fixed();
      dbase = done_cnt;
      rbase = rd_log.size();
      send_frame(0, 1'b0, 1'b0);
      wait_done(dbase + 1);
      check_latches("nostall");
      chk("frame_len", 32'(frame_len), 32'd76);
      chk("rd_count", 32'(rd_log.size() - rbase), 32'd2);
      if (rd_log.size() - rbase == 2) begin
         chk("rd0_dplane", 32'(rd_log[rbase]), 32'hAA);
         chk("rd1_dplane", 32'(rd_log[rbase+1]), 32'h55);
      end
      repeat (3) tick();
      chk("single_done", 32'(done_cnt - dbase), 32'd1);

      // Flop state 0x1234 restored into the chain after the D latch.
      pre_after_d = 1'b1;
      preload_val = 16'h1234;
      rbase = rd_log.size();
      send_frame(0, 1'b0, 1'b0);
      wait_done(dbase + 2);
      chk("rb_count", 32'(rd_log.size() - rbase), 32'd2);
      if (rd_log.size() - rbase == 2) begin
         chk("rb0_data", 32'(rd_log[rbase]), 32'h34);
         chk("rb1_data", 32'(rd_log[rbase+1]), 32'h12);
         chk("rb0_not_done", 32'(rd_dn_log[rbase]), 32'd0);
         chk("rb1_with_done", 32'(rd_dn_log[rbase+1]), 32'd1);
      end
      pre_after_d = 1'b0;

      // Five idle cycles between bytes.
      send_frame(5, 1'b0, 1'b0);
      wait_done(dbase + 3);
      check_latches("stall");

      // 0xEE offered whenever the loader is not ready.
      send_frame(0, 1'b1, 1'b0);
      wait_done(dbase + 4);
      check_latches("ee");

      // Reset at shift cycle 7 of plane 1, then a clean frame.
      for (int j = 0; j < 2*NB; j++) send_byte(frame[j], 1'b0);
      repeat (7) tick();
      chk("pre_rst_se", 32'(bus.out_se), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("post_rst_se", 32'(bus.out_se), 32'd0);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_ready", 32'(bus.s_ready), 32'd1);
      chk("post_rst_cfg", 32'(bus.out_cfg), 32'd0);
      dbase = done_cnt;
      send_frame(0, 1'b0, 1'b0);
      wait_done(dbase + 1);
      check_latches("after_rst");

      // Back-to-back frames.
      send_frame(0, 1'b0, 1'b0);
      send_frame(0, 1'b0, 1'b1);
      wait_done(dbase + 3);

      // Randomised frames, stalls, 0xEE offers and restored flop state.
      for (int r = 0; r < 8; r++) begin
         for (int j = 0; j < 4*NB; j++) frame[j] = 8'($urandom);
         pre_after_d = 1'($urandom);
         preload_val = 16'($urandom);
         send_frame(-1, 1'($urandom), 1'b0);
         wait_done(dbase + 4 + r);
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/p12_cfg_loader.md
Name:
p12_cfg_loader

Overview:
- Byte-stream configuration loader that sits directly upstream of the p12 tile grid.
- Drives the grid's scan-enable, scan-in and configuration-latch-selector pins.
- Accepts a frame of four planes (vertical-flip, horizontal-flip, diagonal-flip, flop state) over a valid/ready byte interface.
- Buffers each plane completely, then shifts it into the scan chain without interruption.
- While the state plane is shifted in, captures the old flop state from the chain's return path and emits it as readback bytes.

Parameters:
- CHAIN_LEN, 64: scan chain length in bits (one plane); must be a multiple of 8 and at least 8.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous and active-high
- s_valid  input  1  byte offered by host
- s_data  input  8  byte payload; LSB is the first bit shifted
- s_ready  output  1  loader can accept a byte this cycle
- out_se  output  1  to grid scan enable
- out_sc  output  1  to grid scan chain input
- out_cfg  output  2  to grid configuration latch selector (0 = none, 1 = V, 2 = H, 3 = D)
- in_sc_ret  input  1  from grid scan chain output
- rd_valid  output  1  one-cycle strobe: rd_data holds a readback byte
- rd_data  output  8  readback byte, first-captured bit in LSB
- busy  output  1  a frame is in progress
- done  output  1  one-cycle strobe at end of frame

Behaviour:
- Reset: the following apply at the first clk edge with rst=1, regardless of the current state.
  - Outputs: s_ready=1, out_se=0, out_sc=0, out_cfg=0, rd_valid=0, rd_data=0, busy=0, done=0.
  - Internal: plane index p=0, byte count=0, bit count=0, plane buffer cleared, state FILL.
  - Reset in mid-shift leaves the grid chain partially shifted; no recovery is attempted.
- States:
  - FILL:
    - s_ready=1, out_se=0, out_cfg=0.
    - A handshake (s_valid & s_ready) stores s_data into buffer bits [8k+7:8k], where k is the byte count, then increments k.
    - The handshake that delivers byte CHAIN_LEN/8-1 moves to SHIFT on the next cycle.
  - SHIFT:
    - s_ready=0, out_se=1, out_cfg=0, out_sc=buffer[i] for i=0..CHAIN_LEN-1 on consecutive cycles, with no gaps.
    - After cycle i=CHAIN_LEN-1:
      - p<3: go to LATCH.
      - p=3: go to DONE.
  - LATCH:
    - One cycle: out_se=0, out_sc=0, out_cfg=p+1, s_ready=0.
    - Then p increments, k is cleared, and the next state is FILL.
  - DONE:
    - One cycle: done=1, out_se=0, s_ready=0.
    - Then p=0, k=0, and the next state is FILL.
- Outputs are registered. out_se, out_sc and out_cfg change only on clk edges.
- Readback:
  - Active only when p=3, in SHIFT.
  - In shift cycle i, in_sc_ret is sampled into readback bit (i mod 8).
  - In the cycle after sampling bit 7 of a byte, rd_valid=1 and rd_data holds that byte.
  - There is no backpressure on readback.
  - The last readback byte's rd_valid coincides with the DONE cycle.
  - Exactly CHAIN_LEN/8 readback bytes are produced per frame.
  - Planes 0–2 produce no readback.
- busy is 1 from the first accepted byte of plane 0 through the DONE cycle inclusive; it is 0 in FILL with p=0 and k=0.
- Host stalls:
  - Stalls are allowed only in FILL.
  - Gaps between bytes do not disturb the grid, because out_se=0 and out_cfg=0 there.
  - s_valid asserted while s_ready=0 is ignored and the byte is not consumed.
- Frame order is fixed: V, H, D, then state. There is no header and no abort; only rst aborts a frame.
- Cycle count per frame with zero host stall: 4·(CHAIN_LEN/8) fill cycles + 4·CHAIN_LEN shift cycles + 3 latch cycles + 1 done cycle.

Test Plan:
- CHAIN_LEN=16, behavioural 16-bit shift-register chain model, bytes V=0x01,0x80, H=0xFF,0x00, D=0xAA,0x55, S=0x0F,0xF0, streamed with no stalls.
  - Required: out_cfg=1,2,3 each for exactly one cycle, after 16 contiguous out_se=1 cycles each.
  - Required: chain holds, at each latch cycle, 0x8001, 0x00FF and 0x55AA respectively.
  - Required: done pulses once; total frame length 8+64+3+1=76 cycles.
- Same frame, chain model preloaded with 0x1234.
  - Required: rd_valid pulses twice, with rd_data=0x34 then 0x12.
  - Required: the second pulse is in the same cycle as done.
- Host drops s_valid for 5 cycles between every byte.
  - Required: out_se stays 0 during all gaps.
  - Required: each SHIFT run is 16 contiguous cycles; chain contents are identical to the no-stall case.
- s_valid held high with 0xEE while in SHIFT.
  - Required: no byte is accepted (s_ready=0).
  - Required: the next accepted byte is the one offered after the return to FILL.
- rst asserted for one cycle at shift cycle 7 of plane 1.
  - Required: next cycle all outputs at reset values, busy=0.
  - Required: a following full frame loads correctly.
- Back-to-back frames.
  - Required: the first byte of frame 2 is accepted in the cycle after done.
  - Required: busy rises again on that handshake.
